// File: rtl/jump_target_queue_if.sv
// Decoder-to-backend jump queue handshake bundle.
// The queue is the slave; the decoder and backend side is the master.
interface jump_target_queue_if #(
  parameter int IP_WIDTH = 48
);
  logic                in_vld;
  logic                in_rdy;
  logic [IP_WIDTH-1:0] in_ip;
  logic [64:0]         in_constant;
  logic [4:0]          in_jumpType;
  logic                in_isJump;
  logic                in_jumpIndir;
  logic                in_push;
  logic                in_pop;
  logic                in_halt;
  logic                flush;
  logic [3:0]          flush_depth;
  logic                out_vld;
  logic                out_rdy;
  logic [4:0]          out_type;
  logic [IP_WIDTH-1:0] out_tgt;
  logic                out_tgt_vld;
  logic                out_push;
  logic                out_pop;
  logic                out_halt;
  logic                out_thread;
  logic [3:0]          ras_depth;

  modport master (
    output in_vld, in_ip, in_constant,
    output in_jumpType, in_isJump,
    output in_jumpIndir, in_push,
    output in_pop, in_halt,
    output flush, flush_depth, out_rdy,
    input  in_rdy, out_vld, out_type,
    input  out_tgt, out_tgt_vld,
    input  out_push, out_pop, out_halt,
    input  out_thread, ras_depth
  );

  modport slave (
    input  in_vld, in_ip, in_constant,
    input  in_jumpType, in_isJump,
    input  in_jumpIndir, in_push,
    input  in_pop, in_halt,
    input  flush, flush_depth, out_rdy,
    output in_rdy, out_vld, out_type,
    output out_tgt, out_tgt_vld,
    output out_push, out_pop, out_halt,
    output out_thread, ras_depth
  );
endinterface

// File: rtl/jump_target_queue.sv
// Per-thread queue of decoded jumps with computed targets
// and speculative call-depth tracking.
module jump_target_queue #(
  parameter int DEPTH    = 8,
  parameter int IP_WIDTH = 48,
  parameter bit thread   = 1'b0
) (
  input logic clk,
  input logic rst,
  jump_target_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

  typedef struct packed {
    logic [4:0]          jType;
    logic [IP_WIDTH-1:0] tgt;
    logic                tgtVld;
    logic                push;
    logic                pop;
    logic                halt;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  entry_t        newEntry;
  entry_t        nextHead;
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] nextRd;
  logic [PW:0]   count;
  logic [PW:0]   nextCount;
  logic          outVld;
  logic [3:0]    rasDepth;
  logic          flagged;
  logic          enq;
  logic          deq;
  logic          unusedBits;

  assign unusedBits =
    ^{q.in_constant[64:IP_WIDTH], q.in_jumpIndir};

  assign q.in_rdy = (count != FULL);
  assign flagged  = q.in_isJump | q.in_push
                  | q.in_pop | q.in_halt;
  assign enq = q.in_vld & q.in_rdy
             & flagged & ~q.flush;
  assign deq = outVld & q.out_rdy & ~q.flush;

  always_comb begin
    newEntry.jType = q.in_jumpType;
    newEntry.push  = q.in_push;
    newEntry.pop   = q.in_pop;
    newEntry.halt  = q.in_halt;
    unique case (1'b1)
      (q.in_jumpType == 5'b10001): begin
        newEntry.tgt    = '0;
        newEntry.tgtVld = 1'b0;
      end
      (q.in_jumpType == 5'b11001): begin
        newEntry.tgt    = q.in_constant[IP_WIDTH-1:0];
        newEntry.tgtVld = 1'b1;
      end
      default: begin
        newEntry.tgt    = q.in_ip
                        + q.in_constant[IP_WIDTH-1:0];
        newEntry.tgtVld = 1'b1;
      end
    endcase
  end

  // Head is registered: a write into an otherwise empty slot
  // is forwarded into the head register, never combinationally.
  always_comb begin
    nextRd    = rdPtr + PW'(deq);
    nextCount = count + (PW + 1)'(enq)
              - (PW + 1)'(deq);
    nextHead  = (enq && nextRd == wrPtr)
              ? newEntry : mem[nextRd];
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wrPtr] <= newEntry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      outVld   <= 1'b0;
      head     <= '0;
      rasDepth <= '0;
    end else if (q.flush) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      outVld   <= 1'b0;
      rasDepth <= q.flush_depth;
    end else begin
      rdPtr  <= nextRd;
      wrPtr  <= wrPtr + PW'(enq);
      count  <= nextCount;
      outVld <= (nextCount != '0);
      if (nextCount != '0) head <= nextHead;
      if (enq && q.in_push && !q.in_pop
          && rasDepth != 4'd15)
        rasDepth <= rasDepth + 4'd1;
      else if (enq && q.in_pop && !q.in_push
               && rasDepth != 4'd0)
        rasDepth <= rasDepth - 4'd1;
    end
  end

  assign q.out_vld     = outVld;
  assign q.out_type    = head.jType;
  assign q.out_tgt     = head.tgt;
  assign q.out_tgt_vld = head.tgtVld;
  assign q.out_push    = head.push;
  assign q.out_pop     = head.pop;
  assign q.out_halt    = head.halt;
  assign q.out_thread  = thread;
  assign q.ras_depth   = rasDepth;
endmodule
